mem_access: RTL and testbench

//  MEM-stage data-memory access controller for the RV32I core; sits directly upstream of load.

---
 rtl/mem_access.sv | 156 +++++++++++++++
 tb/tb_mem_access.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// MEM-stage data-memory access controller: req/gnt + rvalid transactions, pipeline stall,
// store lane generation and raw load capture. Optional MISALIGN_TRAP_EN rejects misaligned accesses.
module mem_access #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic [5:0]  i_mnemonic,
    input  logic [31:0] i_ALUout,
    input  logic [31:0] i_rs2_data,
    output logic        o_stall,
    output logic        o_DM_req,
    input  logic        i_DM_gnt,
    output logic [31:0] o_DM_addr,
    output logic [3:0]  o_DM_WEB,
    output logic [31:0] o_DM_DI,
    input  logic [31:0] i_DM_DO,
    input  logic        i_DM_rvalid,
    output logic [31:0] o_ld_data,
    output logic        o_ld_valid,
    output logic        o_bus_err
);

    localparam logic [5:0] MN_LB  = 6'd10;
    localparam logic [5:0] MN_LH  = 6'd11;
    localparam logic [5:0] MN_LW  = 6'd12;
    localparam logic [5:0] MN_LBU = 6'd13;
    localparam logic [5:0] MN_LHU = 6'd14;
    localparam logic [5:0] MN_SB  = 6'd15;
    localparam logic [5:0] MN_SH  = 6'd16;
    localparam logic [5:0] MN_SW  = 6'd17;

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t         state;
    logic           ld_flag;
    logic [CW-1:0]  cnt;

    logic           is_mem;
    logic           is_load;
    logic [3:0]     web_n;
    logic [31:0]    di;
    logic           misalign;
    logic           start;
    logic           go;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        is_mem  = 1'b0;
        is_load = 1'b0;
        web_n   = 4'hF;
        di      = i_rs2_data;
        case (i_mnemonic)
            MN_LB, MN_LBU, MN_LH, MN_LHU, MN_LW: begin
                is_mem  = 1'b1;
                is_load = 1'b1;
            end
            MN_SB: begin
                is_mem = 1'b1;
                web_n  = ~(4'b0001 << i_ALUout[1:0]);
                di     = {4{i_rs2_data[7:0]}};
            end
            MN_SH: begin
                is_mem = 1'b1;
                web_n  = i_ALUout[1] ? 4'b0011 : 4'b1100;
                di     = {2{i_rs2_data[15:0]}};
            end
            MN_SW: begin
                is_mem = 1'b1;
                web_n  = 4'b0000;
            end
            default: ;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    always_comb begin
        misalign = 1'b0;
        case (i_mnemonic)
            MN_LW, MN_SW:         misalign = |i_ALUout[1:0];
            MN_LH, MN_LHU, MN_SH: misalign = i_ALUout[0];
            default: ;
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

    assign start   = (state == S_IDLE) && i_valid && is_mem;
    assign go      = start && !misalign;
    // Combinational so the pipeline freezes in the same cycle the access is first seen.
    assign o_stall = go || (state == S_REQ) || (state == S_WAIT);

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= S_IDLE;
            ld_flag    <= 1'b0;
            cnt        <= '0;
            o_DM_req   <= 1'b0;
            o_DM_addr  <= '0;
            o_DM_WEB   <= 4'hF;
            o_DM_DI    <= '0;
            o_ld_data  <= '0;
            o_ld_valid <= 1'b0;
            o_bus_err  <= 1'b0;
        end else begin
            o_ld_valid <= 1'b0;
            o_bus_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && misalign) begin
                        o_bus_err <= 1'b1;
                    end else if (go) begin
                        o_DM_addr <= {i_ALUout[31:2], 2'b00};
                        o_DM_WEB  <= web_n;
                        o_DM_DI   <= di;
                        ld_flag   <= is_load;
                        o_DM_req  <= 1'b1;
                        state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (i_DM_gnt) begin
                        o_DM_req <= 1'b0;
                        o_DM_WEB <= 4'hF;
                        cnt      <= '0;
                        state    <= ld_flag ? S_WAIT : S_DONE;
                    end
                end
                S_WAIT: begin
                    if (i_DM_rvalid) begin
                        o_ld_data  <= i_DM_DO;
                        o_ld_valid <= 1'b1;
                        state      <= S_DONE;
                    end else if (TIMEOUT_CYC != 0 && cnt == CNT_LAST) begin
                        // Abandon the read: report zero data alongside the error pulse.
                        o_ld_data  <= '0;
                        o_ld_valid <= 1'b1;
                        o_bus_err  <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access (TIMEOUT_CYC=4); covers the MISALIGN_TRAP_EN
// build and the default build in the misaligned-word step.
module tb_mem_access;

    localparam logic [5:0] MN_LB  = 6'd10;
    localparam logic [5:0] MN_LW  = 6'd12;
    localparam logic [5:0] MN_SB  = 6'd15;
    localparam logic [5:0] MN_SH  = 6'd16;
    localparam logic [5:0] MN_ADD = 6'd1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic [5:0]  mnemonic;
    logic [31:0] alu_out;
    logic [31:0] rs2_data;
    logic        stall;
    logic        dm_req;
    logic        dm_gnt;
    logic [31:0] dm_addr;
    logic [3:0]  dm_web;
    logic [31:0] dm_di;
    logic [31:0] dm_do;
    logic        dm_rvalid;
    logic [31:0] ld_data;
    logic        ld_valid;
    logic        bus_err;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    mem_access #(.TIMEOUT_CYC(4)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_valid     (valid),
        .i_mnemonic  (mnemonic),
        .i_ALUout    (alu_out),
        .i_rs2_data  (rs2_data),
        .o_stall     (stall),
        .o_DM_req    (dm_req),
        .i_DM_gnt    (dm_gnt),
        .o_DM_addr   (dm_addr),
        .o_DM_WEB    (dm_web),
        .o_DM_DI     (dm_di),
        .i_DM_DO     (dm_do),
        .i_DM_rvalid (dm_rvalid),
        .o_ld_data   (ld_data),
        .o_ld_valid  (ld_valid),
        .o_bus_err   (bus_err)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge; inputs are then changed well clear of the edges.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; valid = 1'b0; mnemonic = MN_ADD; alu_out = '0; rs2_data = '0;
        dm_gnt = 1'b0; dm_do = '0; dm_rvalid = 1'b0;
        #12;
        check("rst_req", 32'(dm_req), 32'h0);
        check("rst_web", 32'(dm_web), 32'hF);
        check("rst_addr", dm_addr, 32'h0);
        check("rst_di", dm_di, 32'h0);
        check("rst_ld_data", ld_data, 32'h0);
        check("rst_ld_valid", 32'(ld_valid), 32'h0);
        check("rst_bus_err", 32'(bus_err), 32'h0);
        check("rst_stall", 32'(stall), 32'h0);
        rst_n = 1'b1;

        // Non-memory instruction: no stall, no request.
        tick();
        valid = 1'b1; mnemonic = MN_ADD; alu_out = 32'h100; #1;
        check("nonmem_stall", 32'(stall), 32'h0);
        tick();
        check("nonmem_req", 32'(dm_req), 32'h0);

        // 1: LW @0x100, gnt in REQ, rvalid on first WAIT cycle.
        mnemonic = MN_LW; alu_out = 32'h100; #1;
        check("lw_stall_idle", 32'(stall), 32'h1);
        tick();
        dm_gnt = 1'b1; #1;
        check("lw_req", 32'(dm_req), 32'h1);
        check("lw_addr", dm_addr, 32'h100);
        check("lw_web", 32'(dm_web), 32'hF);
        check("lw_stall_req", 32'(stall), 32'h1);
        tick();
        dm_gnt = 1'b0; dm_rvalid = 1'b1; dm_do = 32'hDEADBEEF; #1;
        check("lw_req_wait", 32'(dm_req), 32'h0);
        check("lw_stall_wait", 32'(stall), 32'h1);
        check("lw_ld_valid_wait", 32'(ld_valid), 32'h0);
        tick();
        dm_rvalid = 1'b0; valid = 1'b0; #1;
        check("lw_ld_valid", 32'(ld_valid), 32'h1);
        check("lw_ld_data", ld_data, 32'hDEADBEEF);
        check("lw_stall_done", 32'(stall), 32'h0);
        check("lw_bus_err", 32'(bus_err), 32'h0);
        tick();
        check("lw_ld_valid_pulse", 32'(ld_valid), 32'h0);
        check("lw_ld_data_hold", ld_data, 32'hDEADBEEF);

        // 2: SB rs2=0x12345678 @0x203; a stray rvalid outside WAIT must be ignored.
        valid = 1'b1; mnemonic = MN_SB; alu_out = 32'h203; rs2_data = 32'h12345678;
        dm_rvalid = 1'b1; dm_do = 32'h55555555; #1;
        check("sb_stall_idle", 32'(stall), 32'h1);
        tick();
        dm_gnt = 1'b1; #1;
        check("sb_req", 32'(dm_req), 32'h1);
        check("sb_addr", dm_addr, 32'h200);
        check("sb_web", 32'(dm_web), 32'h7);
        check("sb_di", dm_di, 32'h78787878);
        tick();
        dm_gnt = 1'b0; dm_rvalid = 1'b0; valid = 1'b0; #1;
        check("sb_ld_valid", 32'(ld_valid), 32'h0);
        check("sb_req_done", 32'(dm_req), 32'h0);
        check("sb_web_done", 32'(dm_web), 32'hF);
        check("sb_stall_done", 32'(stall), 32'h0);
        check("sb_ld_data_hold", ld_data, 32'hDEADBEEF);
        tick();

        // 3: SH @0x106 with gnt withheld for 5 REQ cycles.
        valid = 1'b1; mnemonic = MN_SH; alu_out = 32'h106; rs2_data = 32'h0000ABCD; #1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("sh_req_held", 32'(dm_req), 32'h1);
            check("sh_addr_held", dm_addr, 32'h104);
            check("sh_web_held", 32'(dm_web), 32'h3);
            check("sh_stall_held", 32'(stall), 32'h1);
        end
        check("sh_di", dm_di, 32'hABCDABCD);
        dm_gnt = 1'b1;
        tick();
        dm_gnt = 1'b0; valid = 1'b0; #1;
        check("sh_stall_done", 32'(stall), 32'h0);
        check("sh_req_done", 32'(dm_req), 32'h0);
        tick();

        // 4: LB with no rvalid: 4 WAIT cycles, then timeout.
        valid = 1'b1; mnemonic = MN_LB; alu_out = 32'h301; #1;
        tick();
        dm_gnt = 1'b1;
        tick();
        dm_gnt = 1'b0; #1;
        for (int i = 0; i < 4; i++) begin
            check("lb_wait_stall", 32'(stall), 32'h1);
            check("lb_wait_bus_err", 32'(bus_err), 32'h0);
            tick();
        end
        valid = 1'b0; #1;
        check("lb_to_bus_err", 32'(bus_err), 32'h1);
        check("lb_to_ld_data", ld_data, 32'h0);
        check("lb_to_ld_valid", 32'(ld_valid), 32'h1);
        check("lb_to_stall", 32'(stall), 32'h0);
        tick();
        check("lb_bus_err_pulse", 32'(bus_err), 32'h0);

        // 6: LW @0x102 (misaligned word).
        valid = 1'b1; mnemonic = MN_LW; alu_out = 32'h102; #1;
`ifdef MISALIGN_TRAP_EN
        check("mis_stall", 32'(stall), 32'h0);
        tick();
        valid = 1'b0; #1;
        check("mis_req", 32'(dm_req), 32'h0);
        check("mis_bus_err", 32'(bus_err), 32'h1);
        tick();
        check("mis_bus_err_pulse", 32'(bus_err), 32'h0);
        check("mis_req_after", 32'(dm_req), 32'h0);
`else
        check("mis_stall", 32'(stall), 32'h1);
        tick();
        dm_gnt = 1'b1; #1;
        check("mis_req", 32'(dm_req), 32'h1);
        check("mis_addr", dm_addr, 32'h100);
        tick();
        dm_gnt = 1'b0; dm_rvalid = 1'b1; dm_do = 32'hCAFEF00D;
        tick();
        dm_rvalid = 1'b0; valid = 1'b0; #1;
        check("mis_ld_valid", 32'(ld_valid), 32'h1);
        check("mis_ld_data", ld_data, 32'hCAFEF00D);
        check("mis_bus_err", 32'(bus_err), 32'h0);
        tick();
`endif

        // 5: reset asserted while in WAIT; a late rvalid afterwards is ignored.
        valid = 1'b1; mnemonic = MN_LW; alu_out = 32'h400; #1;
        tick();
        dm_gnt = 1'b1;
        tick();
        dm_gnt = 1'b0; #1;
        check("rw_stall_wait", 32'(stall), 32'h1);
        #2;
        rst_n = 1'b0; valid = 1'b0; #1;
        check("rw_req", 32'(dm_req), 32'h0);
        check("rw_web", 32'(dm_web), 32'hF);
        check("rw_stall", 32'(stall), 32'h0);
        check("rw_addr", dm_addr, 32'h0);
        tick();
        rst_n = 1'b1; dm_rvalid = 1'b1; dm_do = 32'h0BADF00D;
        tick();
        dm_rvalid = 1'b0; #1;
        check("rw_late_ld_valid", 32'(ld_valid), 32'h0);
        check("rw_late_ld_data", ld_data, 32'h0);
        check("rw_late_stall", 32'(stall), 32'h0);
        tick();
        check("rw_late_ld_valid2", 32'(ld_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
